regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 rd_data  output  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W].
REQ-008 rd_busy  output  NUM_RD  port i addresses a register with a pending (reserved) write.
REQ-009 stall  output  1  OR of all rd_busy bits.
REQ-010 wr_en  input  1  writeback strobe.
REQ-011 wr_addr  input  ADDR_W  writeback register.
REQ-012 wr_data  input  DATA_W  writeback data.
REQ-013 rsv_en  input  1  reservation request for an issuing instruction.
REQ-014 rsv_rt  input  ADDR_W  destination candidate when rsv_dst_sel=0.
REQ-015 rsv_rd  input  ADDR_W  destination candidate when rsv_dst_sel=1.
REQ-016 rsv_dst_sel  input  1  destination select.
REQ-017 rsv_ready  output  1  selected destination is free; reservation is accepted only when rsv_en && rsv_ready.

Function
REQ-018 Reads are combinational; rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
REQ-019 Write: wr_en at edge stores wr_data into reg[wr_addr] and clears busy[wr_addr]; visible on the read ports the following cycle.
REQ-020 Reservation: accepted rsv_en sets busy[dst] at the edge, where dst = rsv_dst_sel ? rsv_rd : rsv_rt.
REQ-021 rsv_ready = 0 when busy[dst]=1 (WAW hazard); a request with rsv_ready=0 changes no state.
REQ-022 Register 0: always reads 0, busy[0] always 0, writes and reservations to it are no-ops, rsv_ready=1 for dst=0.
REQ-023 Same edge, wr_addr == dst, both accepted: data is written, busy remains set (new reservation wins).
REQ-024 Write to a non-busy register is legal: data stored, busy unchanged at 0.
REQ-025 Any number of read ports may address the same register; each returns identical data/busy.
REQ-026 Busy bits form a scoreboard of 2**ADDR_W flops independent of the data array.

Reset
REQ-027 reset asserted: all registers = 0, all busy = 0, immediately and independent of clk.
REQ-028 After reset: rd_data = 0, rd_busy = 0, stall = 0, rsv_ready = 1; wr_en/rsv_en asserted during reset are ignored.

Configuration
REQ-029 Macro REGFILE_SB_BYPASS_EN defined: when wr_en and wr_addr == rd_addr[i] != 0, rd_data[i] = wr_data and rd_busy[i] = 0 in the same cycle, and rsv_ready treats busy[dst] as cleared if wr_addr == dst.
REQ-030 Macro undefined: no forwarding; reads and rsv_ready reflect registered state only (write visible one cycle later).

Structure
REQ-031 Shared package regfile_pkg holds default DATA_W/ADDR_W/NUM_RD constants and the zero-register index constant.
REQ-032 One sub-module, regfile_scoreboard, holds the busy array, rsv_ready and busy-clear/set logic; data array and read muxes live in regfile_sb.

Verification
REQ-033 Reset, then read ports 0/1 at addr 5/31 -> rd_data 0, rd_busy 00, stall 0, rsv_ready 1.
REQ-034 wr_en addr 3 data 0xDEADBEEF; next cycle read addr 3 -> 0xDEADBEEF (same-cycle read returns it only with BYPASS_EN).
REQ-035 rsv_en rt=7 dst_sel=0 -> busy[7]; read 7 -> stall 1; second rsv to 7 -> rsv_ready 0, no change; wr_en 7 -> busy cleared next cycle.
REQ-036 wr_en addr 0 data 0x1234, rsv_en rd=0 -> reads 0 return 0, rd_busy 0, rsv_ready 1.
REQ-037 Same edge wr_en addr 9 and rsv_en rd=9 dst_sel=1 -> reg[9] updated, busy[9] = 1.
REQ-038 Assert reset mid-operation with busy[4]=1 and reg[4]=0x55 -> asynchronously busy[4]=0, reg[4]=0, stall 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the regfile_sb register file slice
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;

  // Register 0 is hardwired: never written, never reserved, always reads 0.
  function automatic logic isZeroReg(input logic [31:0] addr);
    return addr == 32'(ZERO_REG);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking reserved (in-flight) writes
//   Ports: clk, reset (async, active-high); rd_addr -> rd_busy/stall lookups;
//   wr_en/wr_addr clear a busy bit; rsv_en/rsv_rt/rsv_rd/rsv_dst_sel request a
//   reservation, accepted only when rsv_ready.
//   Macro REGFILE_SB_BYPASS_EN: a same-cycle writeback is treated as already
//   clearing its busy bit for rd_busy and rsv_ready.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_rt,
  input  logic [ADDR_W-1:0]        rsv_rd,
  input  logic                     rsv_dst_sel,
  output logic                     rsv_ready
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic [ADDR_W-1:0] dst;
  logic              dstBusy;
  logic              rsvAccept;

  assign dst = rsv_dst_sel ? rsv_rd : rsv_rt;

`ifdef REGFILE_SB_BYPASS_EN
  assign dstBusy = busy[dst] & ~(wr_en && wr_addr == dst);
`else
  assign dstBusy = busy[dst];
`endif

  assign rsv_ready = (dst == ZERO) | ~dstBusy;
  assign rsvAccept = rsv_en & rsv_ready & (dst != ZERO);

  // Set after clear so a reservation landing on the same edge as a writeback
  // to that register leaves it busy for the newly issued producer.
  always_comb begin
    busyNext = busy;
    if (wr_en) busyNext[wr_addr] = 1'b0;
    if (rsvAccept) busyNext[dst] = 1'b1;
    busyNext[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else busy <= busyNext;

  for (genvar i = 0; i < NUM_RD; i++) begin : gBusy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
    assign rd_busy[i] = (a != ZERO) & busy[a] & ~(wr_en && wr_addr == a);
`else
    assign rd_busy[i] = (a != ZERO) & busy[a];
`endif
  end

  assign stall = |rd_busy;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a write-reservation scoreboard
//   Ports: clk, reset (async, active-high); rd_addr/rd_data/rd_busy per read
//   port packed at [i*W +: W]; stall = OR of rd_busy; wr_en/wr_addr/wr_data
//   writeback; rsv_en/rsv_rt/rsv_rd/rsv_dst_sel/rsv_ready destination reservation.
//   Macro REGFILE_SB_BYPASS_EN: forwards wr_data to matching read ports in the
//   same cycle; undefined, writes become visible the cycle after the edge.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_rt,
  input  logic [ADDR_W-1:0]        rsv_rd,
  input  logic                     rsv_dst_sel,
  output logic                     rsv_ready
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
    end else if (wr_en && wr_addr != ZERO) begin
      regs[wr_addr] <= wr_data;
    end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRead
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
    assign rd_data[i*DATA_W +: DATA_W] = (a == ZERO) ? '0 :
                                         (wr_en && wr_addr == a) ? wr_data : regs[a];
`else
    assign rd_data[i*DATA_W +: DATA_W] = (a == ZERO) ? '0 : regs[a];
`endif
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) uScoreboard (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_rt     (rsv_rt),
    .rsv_rd     (rsv_rd),
    .rsv_dst_sel(rsv_dst_sel),
    .rsv_ready  (rsv_ready)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_rt;
  logic [4:0]  rsv_rd;
  logic        rsv_dst_sel;
  logic        rsv_ready;
  int total = 0;
  int bad = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_rt(rsv_rt), .rsv_rd(rsv_rd),
    .rsv_dst_sel(rsv_dst_sel), .rsv_ready(rsv_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = {5'd31, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_0000;
    rsv_en = 1'b1; rsv_rt = 5'd12; rsv_rd = 5'd0; rsv_dst_sel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("reset_data", rd_data, 64'h0);
    chk("reset_busy", {62'h0, rd_busy}, 64'h0);
    chk("reset_stall", {63'h0, stall}, 64'h0);
    chk("reset_ready", {63'h0, rsv_ready}, 64'h1);

    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd3, 5'd3};
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("wr_same_cycle", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
`else
    chk("wr_same_cycle", rd_data, 64'h0);
`endif
    tick();
    idle();
    #1;
    chk("wr_next_cycle", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    chk("wr_nonbusy_busy", {62'h0, rd_busy}, 64'h0);

    rsv_en = 1'b1; rsv_rt = 5'd7; rsv_rd = 5'd20; rsv_dst_sel = 1'b0;
    #1;
    chk("rsv7_ready", {63'h0, rsv_ready}, 64'h1);
    tick();
    idle();
    rd_addr = {5'd7, 5'd3};
    #1;
    chk("rsv7_busy", {62'h0, rd_busy}, 64'h2);
    chk("rsv7_stall", {63'h0, stall}, 64'h1);
    rsv_en = 1'b1;
    #1;
    chk("rsv7_waw", {63'h0, rsv_ready}, 64'h0);
    rsv_rd = 5'd20; rsv_dst_sel = 1'b1;
    #1;
    chk("rsv_rd20_ready", {63'h0, rsv_ready}, 64'h1);
    rsv_dst_sel = 1'b0;
    tick();
    idle();
    rd_addr = {5'd7, 5'd20};
    #1;
    chk("rsv7_nochange", {62'h0, rd_busy}, 64'h2);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
    tick();
    idle();
    #1;
    chk("wb7_busy", {62'h0, rd_busy}, 64'h0);
    chk("wb7_stall", {63'h0, stall}, 64'h0);
    chk("wb7_data", rd_data, {32'h77, 32'h0});

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    rsv_en = 1'b1; rsv_rd = 5'd0; rsv_dst_sel = 1'b1;
    #1;
    chk("r0_ready", {63'h0, rsv_ready}, 64'h1);
    tick();
    idle();
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_data", rd_data, 64'h0);
    chk("r0_busy", {62'h0, rd_busy}, 64'h0);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_5A5A;
    rsv_en = 1'b1; rsv_rd = 5'd9; rsv_rt = 5'd2; rsv_dst_sel = 1'b1;
    tick();
    idle();
    rd_addr = {5'd9, 5'd2};
    #1;
    chk("same_edge_data", rd_data[63:32], 64'hA5A5_5A5A);
    chk("same_edge_busy", {62'h0, rd_busy}, 64'h2);
    rsv_dst_sel = 1'b1;
    #1;
    chk("same_edge_ready", {63'h0, rsv_ready}, 64'h0);

    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    tick();
    idle();
    rsv_en = 1'b1; rsv_rt = 5'd4; rsv_dst_sel = 1'b0;
    tick();
    idle();
    rd_addr = {5'd4, 5'd4};
    #1;
    chk("pre_rst_busy", {62'h0, rd_busy}, 64'h3);
    chk("pre_rst_data", rd_data, {32'h55, 32'h55});
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {62'h0, rd_busy}, 64'h0);
    chk("async_rst_data", rd_data, 64'h0);
    chk("async_rst_stall", {63'h0, stall}, 64'h0);
    rd_addr = {5'd9, 5'd3};
    #1;
    chk("async_rst_others", rd_data, 64'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {63'h0, rsv_ready}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
